// File: rtl/ensm_seq_pkg.sv
// Shared types for the ENSM TDD sequencer.
// State encoding and TX/RX phase-select helpers.
package ensm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RX_SETUP,
    S_RX_ON,
    S_RX_GUARD,
    S_TX_SETUP,
    S_TX_ON,
    S_TX_GUARD
  } ensm_state_t;

  localparam logic PH_RX = 1'b0;
  localparam logic PH_TX = 1'b1;

  function automatic ensm_state_t phase_setup(
    input logic ph
  );
    return (ph == PH_TX) ? S_TX_SETUP : S_RX_SETUP;
  endfunction

endpackage

// File: rtl/ensm_tdd_sequencer_pps_edge_sync.sv
// Three-flop pps synchronizer with a registered rising-edge pulse.
// Only instantiated when ENSM_PPS_SYNC_EN is defined.
module pps_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic pps,
  output logic pps_rise
);

  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[1:0], pps};
    rise_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign pps_rise = rise_q;

endmodule

// File: rtl/ensm_tdd_sequencer.sv
// AD9361 ENSM pin-control TDD sequencer (ENABLE/TXNRX frames).
// Define ENSM_PPS_SYNC_EN to align the first frame of a run to pps.
module ensm_tdd_sequencer
  import ensm_seq_pkg::*;
#(
  parameter int CNT_W     = 24,
  parameter int SETUP_CYC = 4,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic              pps,
  input  logic [CNT_W-1:0]  rx_len,
  input  logic [CNT_W-1:0]  tx_len,
  input  logic [CNT_W-1:0]  guard_len,
  output logic              enable,
  output logic              txnrx,
  output logic              busy,
  output logic              frame_strb,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] SETUP_LD =
    CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ensm_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]  tx_q, tx_d;
  logic [CNT_W-1:0]  gd_q, gd_d;
  logic              enable_q, enable_d;
  logic              txnrx_q, txnrx_d;
  logic              busy_q, busy_d;
  logic              strb_q, strb_d;
  logic              cfg_err_q, cfg_err_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              legal_in, last, fend;
  logic              start, is_final, arm_go;

`ifdef ENSM_PPS_SYNC_EN
  localparam bit ARM_ABORT = 1'b1;
  logic pps_rise;

  pps_edge_sync u_pps (
    .clk      (clk),
    .rstn     (rstn),
    .pps      (pps),
    .pps_rise (pps_rise)
  );

  assign arm_go = pps_rise;
`else
  localparam bit ARM_ABORT = 1'b0;
  logic unused_pps;

  assign unused_pps = pps;
  assign arm_go     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - ONE;
    rx_d     = rx_q;
    tx_d     = tx_q;
    gd_d     = gd_q;
    fend     = 1'b0;
    start    = 1'b0;
    last     = (cnt_q == '0);
    legal_in = (rx_len != '0) || (tx_len != '0);

    unique case (state_q)
      S_IDLE: begin
        if (run && legal_in) begin
          state_d = S_ARM;
          start   = 1'b1;
          rx_d    = rx_len;
          tx_d    = tx_len;
          gd_d    = guard_len;
        end
      end
      S_ARM: begin
        if (ARM_ABORT && !run) begin
          state_d = S_IDLE;
        end else if (arm_go) begin
          state_d = phase_setup(
            (rx_q != '0) ? PH_RX : PH_TX);
          cnt_d   = SETUP_LD;
        end
      end
      S_RX_SETUP: begin
        if (last) begin
          state_d = S_RX_ON;
          cnt_d   = rx_q - ONE;
        end
      end
      S_RX_ON: begin
        if (last) begin
          if (gd_q != '0) begin
            state_d = S_RX_GUARD;
            cnt_d   = gd_q - ONE;
          end else if (tx_q != '0) begin
            state_d = S_TX_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            fend = 1'b1;
          end
        end
      end
      S_RX_GUARD: begin
        if (last) begin
          if (tx_q != '0) begin
            state_d = S_TX_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            fend = 1'b1;
          end
        end
      end
      S_TX_SETUP: begin
        if (last) begin
          state_d = S_TX_ON;
          cnt_d   = tx_q - ONE;
        end
      end
      S_TX_ON: begin
        if (last) begin
          if (gd_q != '0) begin
            state_d = S_TX_GUARD;
            cnt_d   = gd_q - ONE;
          end else begin
            fend = 1'b1;
          end
        end
      end
      S_TX_GUARD: begin
        if (last) fend = 1'b1;
      end
    endcase

    // Seamless restart: next frame's first SETUP follows the strobe.
    if (fend) begin
      if (run && legal_in) begin
        rx_d    = rx_len;
        tx_d    = tx_len;
        gd_d    = guard_len;
        state_d = phase_setup(
          (rx_len != '0) ? PH_RX : PH_TX);
        cnt_d   = SETUP_LD;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Registered strobe: flag the upcoming last cycle of a frame.
    is_final =
      (state_d == S_TX_GUARD) ||
      (state_d == S_TX_ON && gd_d == '0) ||
      (state_d == S_RX_GUARD && tx_d == '0) ||
      (state_d == S_RX_ON && gd_d == '0 &&
       tx_d == '0);
    strb_d = is_final && (cnt_d == '0);

    enable_d = (state_d == S_RX_ON) ||
               (state_d == S_TX_ON);
    txnrx_d  = (state_d == S_TX_SETUP) ||
               (state_d == S_TX_ON) ||
               (state_d == S_TX_GUARD);
    busy_d   = (state_d != S_IDLE);

    cfg_err_d = run && (cfg_err_q ||
      (state_q == S_IDLE && !legal_in));

    if (start) begin
      fcnt_d = '0;
    end else if (strb_q) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      gd_q      <= '0;
      enable_q  <= 1'b0;
      txnrx_q   <= 1'b0;
      busy_q    <= 1'b0;
      strb_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      gd_q      <= gd_d;
      enable_q  <= enable_d;
      txnrx_q   <= txnrx_d;
      busy_q    <= busy_d;
      strb_q    <= strb_d;
      cfg_err_q <= cfg_err_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign enable     = enable_q;
  assign txnrx      = txnrx_q;
  assign busy       = busy_q;
  assign frame_strb = strb_q;
  assign frame_cnt  = fcnt_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/ensm_tdd_sequencer.md
# ensm_tdd_sequencer

Cycle-accurate TDD sequencer for the AD9361 ENSM in pin-control mode. Generates the ENABLE/TXNRX pin pair as repeating RX/TX frames with TXNRX setup time and guard intervals, replacing software-toggled EMIO up_enable/up_txnrx. Sits between the PS register interface, which supplies run and lengths, and the AD9361 interface core's up_enable/up_txnrx inputs. One instance per radio.

## Interface
- CNT_W, 24: width of the length configuration inputs and of the internal down-counter.
- SETUP_CYC, 4: fixed cycles TXNRX is held stable before ENABLE rises. Legal range is ≥1.
- FCNT_W, 16: width of frame_cnt.

Ports (name, direction, width, meaning):
- clk  in  1  core clock; every output is registered on clk.
- rstn  in  1  reset, asynchronous assert, active-low.
- run  in  1  level. High starts or continues framing; low stops framing at the end of the current frame.
- pps  in  1  asynchronous pulse-per-second. Used only when ENSM_PPS_SYNC_EN is defined.
- rx_len  in  CNT_W  ENABLE-high cycles in the RX phase. 0 skips the RX phase.
- tx_len  in  CNT_W  ENABLE-high cycles in the TX phase. 0 skips the TX phase.
- guard_len  in  CNT_W  idle cycles after each ENABLE fall. 0 means no guard.
- enable  out  1  ENSM ENABLE pin (level mode).
- txnrx  out  1  ENSM TXNRX pin; 0 = RX, 1 = TX.
- busy  out  1  high whenever the state is not IDLE.
- frame_strb  out  1  one-cycle pulse on the last cycle of each completed frame.
- frame_cnt  out  FCNT_W  count of completed frames; wraps; cleared on each new run.
- cfg_err  out  1  sticky flag: run was seen with rx_len = tx_len = 0. Cleared when run is low.

## Operation
- States: IDLE, ARM, RX_SETUP, RX_ON, RX_GUARD, TX_SETUP, TX_ON, TX_GUARD.
- IDLE
  - enable=0, txnrx=0.
  - On run=1 with a legal config: latch rx_len/tx_len/guard_len into shadow registers, clear frame_cnt, go to ARM.
  - If both lengths are 0: stay in IDLE and set cfg_err.
- ARM: one cycle without the macro; see Configuration for the macro case. Exits to the first non-skipped phase.
- RX_SETUP: txnrx=0 for SETUP_CYC cycles.
- RX_ON: enable=1 for rx_len cycles.
- RX_GUARD: enable=0 and txnrx=0 for guard_len cycles.
- TX_SETUP: txnrx=1 for SETUP_CYC cycles.
- TX_ON: enable=1 and txnrx=1 for tx_len cycles.
- TX_GUARD: enable=0, txnrx held at 1, for guard_len cycles.
- Phase skipping: a phase with zero length skips its SETUP, ON and GUARD states. guard_len=0 skips both GUARD states.
- Frame end is the last cycle of the final executed state. On that cycle:
  - pulse frame_strb and increment frame_cnt;
  - if run=1: reload the shadows from the inputs and start the next frame at its first phase, with no idle gap;
  - otherwise go to IDLE.
- The inputs are sampled only at frame start. Mid-frame changes are ignored.
- Counting: a single down-counter is loaded with (len−1) on state entry. The state exits on the cycle the counter reads 0.
- Invariant: txnrx never changes while enable=1 or in the cycle enable falls. ENABLE rises only after ≥SETUP_CYC cycles of stable TXNRX.
- run may fall and rise again within a frame; only its value at frame end matters.
- rstn low at any time: all outputs go to 0 and the state to IDLE immediately. The AD9361 sees an ENABLE drop mid-burst; this is accepted.

## Timing
- Reset values: enable=0, txnrx=0, busy=0, frame_strb=0, frame_cnt=0, cfg_err=0.
- Without the macro: run rises at cycle N → ARM at N+1 → RX_SETUP at N+2. enable rises at N+2+SETUP_CYC.
- Frame length is the sum over executed phases of (SETUP_CYC + len + guard_len).
- Back-to-back frames are seamless: the first SETUP state of frame k+1 follows frame_strb directly.
- frame_cnt updates in the cycle after frame_strb.

## Configuration
- ENSM_PPS_SYNC_EN defined:
  - pps passes through a 3-flop synchronizer and rising-edge detector;
  - ARM waits for an edge, and only the first frame is aligned to it;
  - if run falls while in ARM, return to IDLE.
- Not defined: pps is ignored, ARM lasts one cycle, and the synchronizer is not instantiated.

## Structure
- Package ensm_seq_pkg holds:
  - the state enum ensm_state_t;
  - the localparam for the phase-select encoding.
- Optional sub-module pps_edge_sync (synchronizer plus edge detect), instantiated only under ENSM_PPS_SYNC_EN.
- The counter, FSM and output registers stay in the top module.

## Test plan
- SETUP_CYC=2, rx_len=3, tx_len=2, guard_len=1, run held high → 11-cycle frames:
  - enable high for 3 cycles with txnrx=0, then for 2 cycles with txnrx=1;
  - frame_strb every 11 cycles; frame_cnt counts 1,2,3.
- Same config, drop run in the middle of the TX_ON state of frame 2 → frame 2 completes, frame_cnt=2, then IDLE with enable=0, txnrx=0, busy=0.
- rx_len=0, tx_len=4, guard_len=0 → only TX_SETUP+TX_ON; 6-cycle frames, txnrx stays at 1 across frames, enable low 2 cycles between bursts.
- rx_len=tx_len=0 with run=1 → cfg_err=1, busy=0; drop run → cfg_err=0.
- Assert rstn low during RX_ON → enable/txnrx/busy go to 0 the same cycle; after release with run=1, restart from ARM with frame_cnt=0.
- With ENSM_PPS_SYNC_EN: run=1 and no pps → busy=1, enable=0 indefinitely; pps pulse → enable rises exactly 3+1+SETUP_CYC cycles after the pps edge.
